// File: rtl/regfile_op_sequencer.sv
// Sequences one read-execute-writeback pass over the 32x32 register file per command.
// Read addresses are steered away from rd during write-back so the register file commits the write.
module regfile_op_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              cmd_wb,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_zero,
    output logic              flag_ovf
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);
    localparam int unsigned MSB     = DATA_W - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EX,
        S_WB,
        S_DN
    } state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   imm_q;
    logic                wb_q;
    logic [DATA_W-1:0]   res_q;
    logic                zero_q;
    logic                ovf_q;

    logic [DATA_W-1:0]   alu_res_c;
    logic                alu_ovf_c;

    // ALU on the register file read data, valid while in EX
    always_comb begin
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_c = rf_read_data1 + rf_read_data2;
                alu_ovf_c = (rf_read_data1[MSB] == rf_read_data2[MSB]) &&
                            (alu_res_c[MSB] != rf_read_data1[MSB]);
            end
            OP_SUB: begin
                alu_res_c = rf_read_data1 - rf_read_data2;
                alu_ovf_c = (rf_read_data1[MSB] != rf_read_data2[MSB]) &&
                            (alu_res_c[MSB] != rf_read_data1[MSB]);
            end
            OP_AND: alu_res_c = rf_read_data1 & rf_read_data2;
            OP_OR:  alu_res_c = rf_read_data1 | rf_read_data2;
            OP_XOR: alu_res_c = rf_read_data1 ^ rf_read_data2;
            OP_SLL: alu_res_c = rf_read_data1 << rf_read_data2[SHAMT_W-1:0];
            OP_SRL: alu_res_c = rf_read_data1 >> rf_read_data2[SHAMT_W-1:0];
            OP_LDI: alu_res_c = imm_q;
            default: alu_res_c = '0;
        endcase
    end

    // Sequencer: IDLE -> RD -> EX -> WB -> DN -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cmd_ready     <= 1'b1;
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            wb_q          <= 1'b0;
            res_q         <= '0;
            zero_q        <= 1'b0;
            ovf_q         <= 1'b0;
            rf_read_reg1  <= '0;
            rf_read_reg2  <= '0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            rf_write      <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            flag_zero     <= 1'b0;
            flag_ovf      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q         <= cmd_op;
                        rd_q         <= cmd_rd;
                        imm_q        <= cmd_imm;
                        wb_q         <= cmd_wb;
                        rf_read_reg1 <= cmd_rs1;
                        rf_read_reg2 <= cmd_rs2;
                        cmd_ready    <= 1'b0;
                        state        <= S_RD;
                    end
                end
                S_RD: state <= S_EX;
                S_EX: begin
                    res_q  <= alu_res_c;
                    zero_q <= (alu_res_c == '0);
                    ovf_q  <= alu_ovf_c;
                    // Reads are done; park both read ports on a neighbour of rd
                    if (wb_q) begin
                        rf_write      <= 1'b1;
                        rf_write_reg  <= rd_q;
                        rf_write_data <= alu_res_c;
                        rf_read_reg1  <= rd_q ^ ADDR_W'(1);
                        rf_read_reg2  <= rd_q ^ ADDR_W'(1);
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    rf_write  <= 1'b0;
                    done      <= 1'b1;
                    result    <= res_q;
                    flag_zero <= zero_q;
                    flag_ovf  <= ovf_q;
                    state     <= S_DN;
                end
                S_DN: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    rf_write  <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: behavioural register file, directed table, stream and random checks.
module tb_regfile_op_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, SLL = 3'd5, SRL = 3'd6, LDI = 3'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [DW-1:0] cmd_imm;
    logic          cmd_wb;
    logic [AW-1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [DW-1:0] rf_read_data1 = '0;
    logic [DW-1:0] rf_read_data2 = '0;
    logic [DW-1:0] rf_write_data;
    logic          rf_write;
    logic          done;
    logic [DW-1:0] result;
    logic          flag_zero, flag_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [32] = '{default: '0};

    always #5 clk = ~clk;

    // Register file: registered reads; a write colliding with a read address is dropped
    always @(posedge clk) begin
        rf_read_data1 <= mem[rf_read_reg1];
        rf_read_data2 <= mem[rf_read_reg2];
        if (rf_write && rf_write_reg != rf_read_reg1 && rf_write_reg != rf_read_reg2)
            mem[rf_write_reg] <= rf_write_data;
    end

    regfile_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .cmd_wb(cmd_wb),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_write(rf_write), .done(done), .result(result),
        .flag_zero(flag_zero), .flag_ovf(flag_ovf)
    );

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [DW-1:0] imm;
        logic          wb;
        logic [DW-1:0] exp_res;
        logic          exp_zero;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model computed from the arithmetic definition of each operation
    task automatic model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] imm, output logic [DW-1:0] res,
                         output logic z, output logic o);
        longint s;
        logic [4:0] sh;
        sh = b[4:0];
        o  = 1'b0;
        case (op)
            ADD: begin
                res = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                o = (s > longint'(32'h7FFF_FFFF)) || (s < -longint'(32'h8000_0000));
            end
            SUB: begin
                res = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                o = (s > longint'(32'h7FFF_FFFF)) || (s < -longint'(32'h8000_0000));
            end
            AND_: res = a & b;
            OR_:  res = a | b;
            XOR_: res = a ^ b;
            SLL:  res = a << sh;
            SRL:  res = a >> sh;
            default: res = imm;
        endcase
        z = (res == 0);
    endtask

    task automatic do_cmd(input vec_t v, input string tag);
        logic [DW-1:0] old_rd;
        int cyc, nwr;
        bit busy_bad;
        old_rd = mem[v.rd];
        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_op = v.op; cmd_rd = v.rd; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2;
        cmd_imm = v.imm; cmd_wb = v.wb; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_rd = AW'($urandom); cmd_imm = $urandom;
        cyc = 0; nwr = 0; busy_bad = 1'b0;
        while (done !== 1'b1 && cyc < 12) begin
            if (cmd_ready !== 1'b0) busy_bad = 1'b1;
            if (rf_write === 1'b1) begin
                nwr++;
                chk({tag, "_wb_raddr1"}, 32'(rf_read_reg1), 32'(v.rd ^ 5'd1));
                chk({tag, "_wb_raddr2"}, 32'(rf_read_reg2), 32'(v.rd ^ 5'd1));
                chk({tag, "_wb_wdata"},  rf_write_data, v.exp_res);
            end
            @(posedge clk); #1;
            cyc++;
        end
        // cyc counts edges after the accept edge: done shows up 4 cycles after the accept cycle
        chk({tag, "_latency_edges"}, 32'(cyc), 32'd3);
        chk({tag, "_result"}, result, v.exp_res);
        chk({tag, "_zero"}, 32'(flag_zero), 32'(v.exp_zero));
        chk({tag, "_ovf"}, 32'(flag_ovf), 32'(v.exp_ovf));
        chk({tag, "_write_pulses"}, 32'(nwr), 32'(v.wb));
        chk({tag, "_busy_ready"}, 32'(busy_bad), 32'd0);
        chk({tag, "_ready_dn"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_reg"}, mem[v.rd], v.wb ? v.exp_res : old_rd);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [DW-1:0] q [$];
        logic [DW-1:0] exp_v, last_imm, old5;
        logic z, o;
        int accepts, dones, last_acc, waited;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0;
        cmd_rs2 = '0; cmd_imm = '0; cmd_wb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_write", 32'(rf_write), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, flag_zero, flag_ovf}, 32'd0);
        chk("rst_raddr", {22'd0, rf_read_reg1, rf_read_reg2}, 32'd0);
        chk("rst_waddr", 32'(rf_write_reg), 32'd0);
        chk("rst_wdata", rf_write_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //          op    rd     rs1    rs2    imm            wb    res            z     o
        vecs[0] = '{LDI, 5'd3, 5'd0, 5'd0, 32'h0000_0007, 1'b1, 32'h0000_0007, 1'b0, 1'b0};
        vecs[1] = '{LDI, 5'd4, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[2] = '{ADD, 5'd5, 5'd3, 5'd4, 32'h0,         1'b1, 32'h0000_0006, 1'b0, 1'b0};
        vecs[3] = '{ADD, 5'd3, 5'd3, 5'd3, 32'h0,         1'b1, 32'h0000_000E, 1'b0, 1'b0};
        vecs[4] = '{LDI, 5'd1, 5'd0, 5'd0, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0};
        vecs[5] = '{LDI, 5'd2, 5'd0, 5'd0, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[6] = '{ADD, 5'd6, 5'd1, 5'd2, 32'h0,         1'b1, 32'h8000_0000, 1'b0, 1'b1};
        vecs[7] = '{SUB, 5'd7, 5'd2, 5'd2, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = '{SLL, 5'd8, 5'd3, 5'd2, 32'h0,         1'b0, 32'h0000_001C, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) do_cmd(vecs[i], $sformatf("vec%0d", i));

        // cmd_valid held high; busy-time changes to the command must be ignored
        accepts = 0; dones = 0; last_acc = -1; last_imm = '0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                chk("stream_order", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) chk("stream_result", result, q.pop_front());
            end
            if (cmd_ready === 1'b1) begin
                if (last_acc >= 0) chk("stream_gap", 32'(c - last_acc), 32'd5);
                last_acc = c;
                accepts++;
                last_imm = $urandom;
                q.push_back(last_imm);
                cmd_op = LDI; cmd_rd = 5'd10; cmd_wb = 1'b1; cmd_imm = last_imm;
            end else begin
                cmd_op = 3'($urandom); cmd_rd = AW'($urandom); cmd_rs1 = AW'($urandom);
                cmd_rs2 = AW'($urandom); cmd_imm = $urandom; cmd_wb = 1'($urandom);
            end
            cmd_valid = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("stream_accepts", 32'(accepts), 32'd5);
        chk("stream_dones", 32'(dones), 32'd5);
        chk("stream_r10", mem[10], last_imm);

        // Random commands against the reference model
        for (int i = 0; i < 40; i++) begin
            v.op = 3'($urandom); v.rd = AW'($urandom); v.rs1 = AW'($urandom);
            v.rs2 = AW'($urandom); v.imm = $urandom; v.wb = ($urandom_range(0, 3) != 0);
            if (i % 8 == 0) v.imm = '0;
            model(v.op, mem[v.rs1], mem[v.rs2], v.imm, exp_v, z, o);
            v.exp_res = exp_v; v.exp_zero = z; v.exp_ovf = o;
            do_cmd(v, $sformatf("rnd%0d", i));
        end

        // Reset while the write-back strobe is high
        old5 = mem[5];
        @(negedge clk);
        cmd_op = ADD; cmd_rd = 5'd5; cmd_rs1 = 5'd3; cmd_rs2 = 5'd3; cmd_wb = 1'b1;
        cmd_imm = '0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        waited = 0;
        while (rf_write !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("rstwb_reach_wb", 32'(rf_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstwb_write_async", 32'(rf_write), 32'd0);
        chk("rstwb_ready_async", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstwb_r5_kept", mem[5], old5);
        chk("rstwb_ready", 32'(cmd_ready), 32'd1);
        chk("rstwb_done", 32'(done), 32'd0);
        chk("rstwb_result", result, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
